// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 16-bit multiply / unsigned divide / unsigned remainder.
// A shift-add multiplier and a restoring divider advance together, one step per
// clock, for 16 steps; the op latched at acceptance selects which answer is kept.
// Divide-by-zero and the reserved op finish immediately without iterating.

module mul_div_unit (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [1:0]  op_r;
    logic [31:0] acc_r;       // product accumulator
    logic [31:0] mcand_r;     // multiplicand, shifted left each step
    logic [15:0] mplier_r;    // multiplier, shifted right each step
    logic [15:0] rem_r;       // partial remainder (always < divisor between steps)
    logic [15:0] quo_r;       // dividend bits shifting out, quotient bits shifting in
    logic [15:0] b_r;         // latched divisor

    logic [31:0] acc_nxt_s;
    logic [16:0] rem_shift_s; // 17-bit partial remainder after shifting in a dividend bit
    logic [16:0] diff_s;
    logic [15:0] rem_nxt_s;
    logic [15:0] quo_nxt_s;
    logic [15:0] res_s;

    // One step of each engine, plus selection of the answer after the final step.
    always_comb begin
        acc_nxt_s   = acc_r + (mplier_r[0] ? mcand_r : 32'd0);
        rem_shift_s = {rem_r, quo_r[15]};
        diff_s      = rem_shift_s - {1'b0, b_r};
        // rem_shift < 2*divisor, so the trial difference fits in 17 signed bits
        // and bit 16 is its sign: clear means the divisor fits.
        if (!diff_s[16]) begin
            rem_nxt_s = diff_s[15:0];
            quo_nxt_s = {quo_r[14:0], 1'b1};
        end else begin
            rem_nxt_s = rem_shift_s[15:0];
            quo_nxt_s = {quo_r[14:0], 1'b0};
        end
        case (op_r)
            OP_MUL:  res_s = acc_nxt_s[15:0];
            OP_DIVU: res_s = quo_nxt_s;
            OP_REMU: res_s = rem_nxt_s;
            default: res_s = 16'h0000;
        endcase
    end

    // Control FSM with registered busy/done/result/dz and the iteration registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r  <= IDLE;
            cnt_r    <= 5'd0;
            op_r     <= 2'b00;
            acc_r    <= 32'd0;
            mcand_r  <= 32'd0;
            mplier_r <= 16'd0;
            rem_r    <= 16'd0;
            quo_r    <= 16'd0;
            b_r      <= 16'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= 16'h0000;
            dz       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r     <= op;
                        cnt_r    <= 5'd0;
                        acc_r    <= 32'd0;
                        mcand_r  <= {16'd0, A};
                        mplier_r <= B;
                        rem_r    <= 16'd0;
                        quo_r    <= A;
                        b_r      <= B;
                        busy     <= 1'b1;
                        if (op == 2'b11) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                            result  <= 16'h0000;
                            dz      <= 1'b0;
                        end else if ((op != OP_MUL) && (B == 16'd0)) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                            result  <= (op == OP_DIVU) ? 16'hFFFF : A;
                            dz      <= 1'b1;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    cnt_r    <= cnt_r + 5'd1;
                    acc_r    <= acc_nxt_s;
                    mcand_r  <= {mcand_r[30:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[15:1]};
                    rem_r    <= rem_nxt_s;
                    quo_r    <= quo_nxt_s;
                    if (cnt_r == 5'd15) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        result  <= res_s;
                        dz      <= 1'b0;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected results are queued at acceptance
// and compared when the done pulse appears.

module tb_mul_div_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] A = 16'h0000;
    logic [15:0] B = 16'h0000;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        dz;

    int compares = 0;
    int fails    = 0;

    typedef struct {
        logic [15:0] res;
        logic        dz;
    } exp_t;

    exp_t sb[$];

    mul_div_unit dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .dz      (dz)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] p;
        case (o)
            2'b00: begin
                p     = 32'(a) * 32'(b);
                e.res = p[15:0];
                e.dz  = 1'b0;
            end
            2'b01: begin
                e.res = (b == 16'd0) ? 16'hFFFF : a / b;
                e.dz  = (b == 16'd0);
            end
            2'b10: begin
                e.res = (b == 16'd0) ? a : a % b;
                e.dz  = (b == 16'd0);
            end
            default: begin
                e.res = 16'h0000;
                e.dz  = 1'b0;
            end
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, optionally firing stray starts at cycles 5 and 17, and check it.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input int exp_lat, input bit inject);
        exp_t e;
        int   lat;
        @(negedge Clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        A  = 16'($urandom);
        B  = 16'($urandom);
        op = 2'($urandom_range(3));
        sb.push_back(model(o, a, b));
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clk);
            if (inject && (n == 5 || n == 17)) begin
                start = 1'b1; op = 2'b01; A = 16'h7777; B = 16'h0003;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy_at_done"}, 32'(busy), 32'd1);
        e = sb.pop_front();
        check({tag, " result"}, 32'(result), 32'(e.res));
        check({tag, " dz"}, 32'(dz), 32'(e.dz));
        @(posedge Clk);
        #1;
        start = 1'b0;
        @(negedge Clk);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        check({tag, " done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   dcount;
        int   t0, t1, k;

        // Reset state
        repeat (2) @(negedge Clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'h0000);
        check("rst dz", 32'(dz), 32'd0);
        Reset_n = 1'b1;

        run_op("mul_3x5",       2'b00, 16'h0003, 16'h0005, 17, 1'b0);
        run_op("mul_ffffx2",    2'b00, 16'hFFFF, 16'h0002, 17, 1'b0);
        run_op("mul_trunc",     2'b00, 16'h1234, 16'h0100, 17, 1'b0);
        run_op("mul_by_zero",   2'b00, 16'hABCD, 16'h0000, 17, 1'b0);
        run_op("divu_100_7",    2'b01, 16'h0064, 16'h0007, 17, 1'b0);
        run_op("remu_100_7",    2'b10, 16'h0064, 16'h0007, 17, 1'b0);
        run_op("divu_5_9",      2'b01, 16'h0005, 16'h0009, 17, 1'b0);
        run_op("divu_ffff_1",   2'b01, 16'hFFFF, 16'h0001, 17, 1'b0);
        run_op("remu_ffff_ff",  2'b10, 16'hFFFF, 16'h00FF, 17, 1'b0);
        run_op("divu_by_zero",  2'b01, 16'h1234, 16'h0000, 1, 1'b0);
        run_op("remu_by_zero",  2'b10, 16'h1234, 16'h0000, 1, 1'b0);
        run_op("op_reserved",   2'b11, 16'h5555, 16'h0003, 1, 1'b0);

        // Stray starts while busy must be ignored
        run_op("mul_busy_ign",  2'b00, 16'h00AB, 16'h0011, 17, 1'b1);
        dcount = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (done) dcount++;
        end
        check("busy_ign no_extra_done", 32'(dcount), 32'd0);
        check("busy_ign result_held", 32'(result), 32'h0B5B);
        check("busy_ign idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a divide
        @(negedge Clk);
        op = 2'b01; A = 16'hBEEF; B = 16'h0013; start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        sb.push_back(model(2'b01, 16'hBEEF, 16'h0013));
        repeat (8) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", 32'(result), 32'h0000);
        check("abort dz", 32'(dz), 32'd0);
        e = sb.pop_front();
        dcount = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge Clk);
            if (done) dcount++;
        end
        check("abort no_done", 32'(dcount), 32'd0);
        Reset_n = 1'b1;
        run_op("mul_after_rst", 2'b00, 16'h0101, 16'h0202, 17, 1'b0);

        // start held high: one operation per 18 cycles
        @(negedge Clk);
        op = 2'b00; A = 16'h0007; B = 16'h0009; start = 1'b1;
        sb.push_back(model(2'b00, 16'h0007, 16'h0009));
        sb.push_back(model(2'b00, 16'h0007, 16'h0009));
        k = 0; t0 = 0; t1 = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clk);
            if (done) begin
                if (k == 0) t0 = c; else t1 = c;
                e = sb.pop_front();
                check("held result", 32'(result), 32'(e.res));
                k++;
                if (k == 2) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        check("held done_count", 32'(k), 32'd2);
        check("held period", 32'(t1 - t0), 32'd18);
        repeat (2) @(negedge Clk);
        check("held idle", 32'(busy), 32'd0);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit for the SLC-3 datapath, placed directly downstream of the register file. It takes the two register-file read ports (SR1 and SR2 values) as operands and computes a 16-bit product, quotient or remainder using an iterative shift-add / restoring-divide engine. The result is presented for the control FSM to gate onto the bus and write back through the register file's normal load path. A start/busy/done handshake lets the ISDU stall while the unit iterates.

## Interface
- Parameters: none; data width fixed at 16 bits (the SLC-3 word).
- Clk  input  1  rising-edge clock for all state.
- Reset_n  input  1  asynchronous, active-low reset; one clock domain, async assert.
- start  input  1  request; sampled only when the unit is idle.
- op  input  2  00 MUL, 01 DIVU (quotient), 10 REMU (remainder), 11 reserved.
- A  input  16  operand 1, driven from the register file's SR1 read port.
- B  input  16  operand 2, driven from the register file's SR2 read port.
- busy  output  1  high while the unit is in RUN or DONE.
- done  output  1  one-cycle pulse; result and dz are valid in this cycle.
- result  output  16  registered result; held until the next completion.
- dz  output  1  divide-by-zero flag, registered with result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: when start=1, latch A, B and op, clear the 5-bit iteration counter, then go to RUN.
  - Exception: DIVU/REMU with B=0 goes directly to DONE.
  - Exception: op=11 goes directly to DONE.
- RUN: one iteration per clock; after the 16th iteration (counter=15) go to DONE, loading result/dz.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in RUN and in DONE. No queuing: a dropped start must be reissued.
- Operands are captured at acceptance, so A/B may change afterwards without effect.
- MUL:
  - Unsigned shift-add over 16 multiplier bits; 32-bit accumulator internally.
  - result = low 16 bits of the product. These bits are identical for two's-complement operands.
- DIVU/REMU:
  - Restoring division with a 17-bit partial remainder. Each iteration shifts in the next dividend MSB and subtracts B when it fits, setting the quotient bit.
  - DIVU result = 16-bit quotient; REMU result = 16-bit remainder.
- Divide by zero: result=0xFFFF for DIVU, result=A for REMU; dz=1.
- op=11: result=0x0000, dz=0.
- dz=0 for every other completion.

## Timing
- Reset values: busy=0, done=0, result=0x0000, dz=0, state=IDLE, counter=0.
- Reset assertion mid-operation aborts immediately: no done pulse, and result is cleared to 0x0000.
- Edge numbering: start is accepted at edge E0.
  - Normal op: iterations occur at E1..E16. done=1 in the cycle after E16; result changes at E16. IDLE is re-entered at E17.
  - Normal op: busy is high from E0 through E17. Start-to-done latency is 17 cycles.
  - Zero-divisor and op=11: DONE is entered at E0, done=1 in the next cycle, IDLE at E1. Latency is 1 cycle.
- Back-to-back operation: the earliest next acceptance is the edge at which IDLE is observed, i.e. the E17-plus-one edge for a normal op.
- start held high continuously produces one operation per 18 cycles.
- result/dz are stable outside done pulses and change only at the edge entering DONE.

## Test plan
- Reset, then MUL A=0x0003 B=0x0005 -> done pulses exactly 17 cycles after the accepting edge, result=0x000F, dz=0; busy low two edges later.
- MUL A=0xFFFF B=0x0002 -> result=0xFFFE. MUL A=0x1234 B=0x0100 -> result=0x3400 (truncation).
- DIVU A=0x0064 B=0x0007 -> result=0x000E. REMU on the same operands -> result=0x0002. DIVU A=0x0005 B=0x0009 -> 0x0000.
- DIVU A=0x1234 B=0x0000 -> done 1 cycle after acceptance, result=0xFFFF, dz=1. REMU on the same operands -> result=0x1234, dz=1.
- Busy rules:
  - Pulse start with new operands at cycles 5 and 17 of a running MUL -> both ignored; the original result is unchanged.
  - A single done pulse is produced, and the next start is accepted only after busy falls.
- Drop Reset_n asynchronously at iteration 8 of a DIVU -> busy/done/result/dz read 0 immediately with no done pulse. A fresh MUL after release completes correctly.
